// File: rtl/vga_timing_pkg.sv
// Raster timing constants, colour/coordinate widths and a window-decode helper
// shared by the scanout block and its timing counter.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned COLOR_W  = 10;
    localparam int unsigned COORD_W  = 10;

    typedef logic [COLOR_W-1:0] chan_t;

    typedef struct packed {
        chan_t r;
        chan_t g;
        chan_t b;
    } rgb_t;

    // True when c lies in [lo, lo+len-1]; done in 32 bits so the bounds never truncate.
    function automatic logic in_window(input logic [COORD_W-1:0] c,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (32'(c) >= lo) && (32'(c) < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical raster counters with active-area and sync-window decode.
module vga_timing_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic [COORD_W-1:0] hcnt,
    output logic [COORD_W-1:0] vcnt,
    output logic               active,
    output logic               hs_act,
    output logic               vs_act
);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    // Advance one pixel per strobe; the line wrap carries into the line counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Decode the visible area and the two sync windows from the current position.
    always_comb begin
        active = in_window(hcnt, 0, H_ACTIVE) && in_window(vcnt, 0, V_ACTIVE);
        hs_act = in_window(hcnt, H_ACTIVE + H_FP, H_SYNC);
        vs_act = in_window(vcnt, V_ACTIVE + V_FP, V_SYNC);
    end

endmodule

// File: rtl/vga_overlay_scanout.sv
// Scanout stage: publishes raster position to the overlay layers, merges the
// overlay result over the background and registers colour with sync/blank.
module vga_overlay_scanout
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    input  logic [COLOR_W-1:0] ov_r,
    input  logic [COLOR_W-1:0] ov_g,
    input  logic [COLOR_W-1:0] ov_b,
    input  logic               ov_printed,
    input  logic [COLOR_W-1:0] bg_r,
    input  logic [COLOR_W-1:0] bg_g,
    input  logic [COLOR_W-1:0] bg_b,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               hsync,
    output logic               vsync,
    output logic               blank_n,
    output logic               frame_start
);

    logic [COORD_W-1:0] hcnt;
    logic [COORD_W-1:0] vcnt;
    logic               active;
    logic               hs_act;
    logic               vs_act;
    rgb_t               mix;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .hcnt   (hcnt),
        .vcnt   (vcnt),
        .active (active),
        .hs_act (hs_act),
        .vs_act (vs_act)
    );

    assign px = hcnt;
    assign py = vcnt;

    // Overlay wins only on its printed flag; outside the visible area drive black.
    always_comb begin
        mix = '0;
        if (active) begin
            mix = ov_printed ? rgb_t'{ov_r, ov_g, ov_b} : rgb_t'{bg_r, bg_g, bg_b};
        end
    end

    // Single output stage keeps colour, sync and blank aligned one slot behind px/py.
    // frame_start is cleared on every non-strobe clk so it stays one clk wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && (hcnt == '0) && (vcnt == '0);
            if (pix_en) begin
                vga_r   <= mix.r;
                vga_g   <= mix.g;
                vga_b   <= mix.b;
                hsync   <= hs_act ? SYNC_POL : ~SYNC_POL;
                vsync   <= vs_act ? SYNC_POL : ~SYNC_POL;
                blank_n <= active;
            end
        end
    end

endmodule

// File: tb/tb_vga_overlay_scanout.sv
// Bench: a full-size instance checks the real line timing; a shrunken-raster
// instance is checked slot by slot against a scoreboard over whole frames.
module tb_vga_overlay_scanout;

    // Shrunken raster: 32 x 20 slots, so complete frames fit in a short run.
    localparam int unsigned SH_A = 16, SH_FP = 4, SH_S = 6, SH_BP = 6;
    localparam int unsigned SV_A = 12, SV_FP = 2, SV_S = 2, SV_BP = 4;
    localparam int unsigned SH_T = SH_A + SH_FP + SH_S + SH_BP;
    localparam int unsigned SV_T = SV_A + SV_FP + SV_S + SV_BP;

    typedef struct {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // ---------------- full-size instance ----------------
    logic       rst_d = 1'b1, pix_en_d = 1'b0;
    logic [9:0] px_d, py_d, r_d, g_d, b_d;
    logic       hsync_d, vsync_d, blank_d, fs_d;

    vga_overlay_scanout u_dut_full (
        .clk(clk), .rst(rst_d), .pix_en(pix_en_d),
        .px(px_d), .py(py_d),
        .ov_r(10'h000), .ov_g(10'h000), .ov_b(10'h3FF), .ov_printed(1'b0),
        .bg_r(10'h155), .bg_g(10'h155), .bg_b(10'h155),
        .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
        .hsync(hsync_d), .vsync(vsync_d), .blank_n(blank_d), .frame_start(fs_d)
    );

    // ---------------- shrunken instance ----------------
    logic       rst_s = 1'b1, pix_en_s = 1'b0, ovp_s = 1'b0;
    logic [9:0] ov_r_s = '0, ov_g_s = '0, ov_b_s = '0;
    logic [9:0] bg_r_s = '0, bg_g_s = '0, bg_b_s = '0;
    logic [9:0] px_s, py_s, r_s, g_s, b_s;
    logic       hsync_s, vsync_s, blank_s, fs_s;

    vga_overlay_scanout #(
        .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP),
        .SYNC_POL(1'b0)
    ) u_dut_small (
        .clk(clk), .rst(rst_s), .pix_en(pix_en_s),
        .px(px_s), .py(py_s),
        .ov_r(ov_r_s), .ov_g(ov_g_s), .ov_b(ov_b_s), .ov_printed(ovp_s),
        .bg_r(bg_r_s), .bg_g(bg_g_s), .bg_b(bg_b_s),
        .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
        .hsync(hsync_s), .vsync(vsync_s), .blank_n(blank_s), .frame_start(fs_s)
    );

    exp_t        sb[$];
    exp_t        held;
    int unsigned mh = 0, mv = 0;
    int unsigned fs_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_out(input string tag, input exp_t e);
        check({tag, "_r"},  32'(r_s),     32'(e.r));
        check({tag, "_g"},  32'(g_s),     32'(e.g));
        check({tag, "_b"},  32'(b_s),     32'(e.b));
        check({tag, "_hs"}, 32'(hsync_s), 32'(e.hs));
        check({tag, "_vs"}, 32'(vsync_s), 32'(e.vs));
        check({tag, "_bn"}, 32'(blank_s), 32'(e.bn));
        check({tag, "_fs"}, 32'(fs_s),    32'(e.fs));
    endtask

    function automatic exp_t reset_item();
        exp_t e;
        e.r = '0; e.g = '0; e.b = '0;
        e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0; e.fs = 1'b0;
        return e;
    endfunction

    // One clk on the shrunken instance: drive inputs for the model position,
    // queue the expected output on a strobe, compare after the edge.
    task automatic s_step(input logic en);
        exp_t e;
        logic act, pr;
        @(negedge clk);
        pix_en_s = en;
        pr = (mh == 7 && mv == 5) || (mh >= 20) || (mv >= 14 && mh == 3);
        ovp_s  = pr;
        ov_r_s = 10'h000; ov_g_s = 10'h000; ov_b_s = 10'h3FF;
        bg_r_s = 10'((mh * 3 + mv) | 1); bg_g_s = 10'h155; bg_b_s = 10'h155;
        check("s_px", 32'(px_s), mh);
        check("s_py", 32'(py_s), mv);
        if (en) begin
            act  = (mh < SH_A) && (mv < SV_A);
            e.r  = !act ? 10'h000 : (pr ? ov_r_s : bg_r_s);
            e.g  = !act ? 10'h000 : (pr ? ov_g_s : bg_g_s);
            e.b  = !act ? 10'h000 : (pr ? ov_b_s : bg_b_s);
            e.hs = !(mh >= SH_A + SH_FP && mh < SH_A + SH_FP + SH_S);
            e.vs = !(mv >= SV_A + SV_FP && mv < SV_A + SV_FP + SV_S);
            e.bn = act;
            e.fs = (mh == 0 && mv == 0);
            sb.push_back(e);
            mh++;
            if (mh == SH_T) begin
                mh = 0;
                mv++;
                if (mv == SV_T) mv = 0;
            end
        end
        @(posedge clk);
        #1;
        if (fs_s) fs_seen++;
        if (en) begin
            if (sb.size() == 0) begin
                check("s_sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                cmp_out("s", e);
                held = e;
            end
        end else begin
            e = held;
            e.fs = 1'b0;
            cmp_out("s_hold", e);
        end
    endtask

    // Reset the shrunken instance with pix_en high; reset must dominate.
    task automatic s_reset(input int unsigned cycles);
        @(negedge clk);
        rst_s = 1'b1;
        pix_en_s = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        check("s_rst_px", 32'(px_s), 0);
        check("s_rst_py", 32'(py_s), 0);
        cmp_out("s_rst", reset_item());
        @(negedge clk);
        rst_s = 1'b0;
        pix_en_s = 1'b0;
        mh = 0;
        mv = 0;
        sb.delete();
        held = reset_item();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        prev;
        int unsigned first_fall, second_fall, low_cnt, fall_after;

        // ---- full-size instance: reset state and real line timing ----
        rst_d = 1'b1;
        pix_en_d = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("d_rst_px", 32'(px_d), 0);
        check("d_rst_py", 32'(py_d), 0);
        check("d_rst_rgb", {2'b0, r_d, g_d, b_d}, 0);
        check("d_rst_hs", 32'(hsync_d), 1);
        check("d_rst_vs", 32'(vsync_d), 1);
        check("d_rst_bn", 32'(blank_d), 0);
        check("d_rst_fs", 32'(fs_d), 0);
        @(negedge clk);
        rst_d = 1'b0;

        prev = 1'b1;
        first_fall = 0;
        second_fall = 0;
        low_cnt = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                check("d_px_first", 32'(px_d), 1);
                check("d_fs_first", 32'(fs_d), 1);
            end
            if (k == 2) check("d_fs_width", 32'(fs_d), 0);
            if (k == 640) check("d_bn_last_vis", 32'(blank_d), 1);
            if (k == 641) check("d_bn_first_blk", 32'(blank_d), 0);
            if (k <= 800 && !hsync_d) low_cnt++;
            if (prev && !hsync_d) begin
                if (first_fall == 0) first_fall = k;
                else if (second_fall == 0) second_fall = k;
            end
            prev = hsync_d;
        end
        check("d_hs_first_fall", first_fall, 657);
        check("d_hs_low_width", low_cnt, 96);
        check("d_hs_period", second_fall - first_fall, 800);
        check("d_vs_idle", 32'(vsync_d), 1);
        check("d_mid_px", 32'(px_d), 400);
        check("d_mid_py", 32'(py_d), 2);

        // mid-line reset: back to (0,0), no sync pulse until hcnt reaches 656 again
        @(negedge clk);
        rst_d = 1'b1;
        @(posedge clk);
        #1;
        check("d_mrst_px", 32'(px_d), 0);
        check("d_mrst_py", 32'(py_d), 0);
        check("d_mrst_hs", 32'(hsync_d), 1);
        @(negedge clk);
        rst_d = 1'b0;
        fall_after = 0;
        for (int j = 1; j <= 2000; j++) begin
            @(posedge clk);
            #1;
            if (!hsync_d) begin
                fall_after = j;
                break;
            end
        end
        check("d_mrst_hs_fall", fall_after, 657);
        pix_en_d = 1'b0;

        // ---- shrunken instance: scoreboard over whole frames ----
        s_reset(2);
        fs_seen = 0;
        for (int i = 0; i < 2 * SH_T * SV_T + 2; i++) s_step(1'b1);
        check("s_fs_count_cont", fs_seen, 3);

        fs_seen = 0;
        for (int i = 0; i < 2800; i++) s_step((i % 4) == 0);
        check("s_fs_count_strobe", fs_seen, 1);

        s_reset(1);
        for (int i = 0; i < 200; i++) s_step(1'b1);
        check("s_sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
